// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master that feeds the Sobel slave pixel port.
package spi_pkg;

  localparam int unsigned MAX_PIXEL_BITS = 8;

  // SPI mode 0, MSB first
  localparam bit CPOL      = 1'b0;
  localparam bit CPHA      = 1'b0;
  localparam bit MSB_FIRST = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CS_SETUP = 3'd1,
    S_SHIFT    = 3'd2,
    S_CS_HOLD  = 3'd3,
    S_GAP      = 3'd4
  } state_e;

  // Width of a counter running 0..n-1, never less than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_master_control_if.sv
// System-side pixel handshake and returned-word bus of the SPI master.
interface spi_master_control_if
  import spi_pkg::*;
#(
  parameter int unsigned DATA_BITS = MAX_PIXEL_BITS
);

  logic [DATA_BITS-1:0] tx_data_i;
  logic                 tx_valid_i;
  logic                 tx_ready_o;
  logic [DATA_BITS-1:0] rx_data_o;
  logic                 rx_valid_o;
  logic                 busy_o;

  // Caller side
  modport master (
    output tx_data_i, tx_valid_i,
    input  tx_ready_o, rx_data_o, rx_valid_o, busy_o
  );

  // SPI master side
  modport slave (
    input  tx_data_i, tx_valid_i,
    output tx_ready_o, rx_data_o, rx_valid_o, busy_o
  );

endinterface

// File: rtl/spi_master_clkgen.sv
// SCK generator: half-period counter that toggles sck every CLK_DIV enabled cycles.
module spi_master_clkgen
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic nreset_i,
  input  logic en,
  output logic sck,
  output logic rise_stb_c,
  output logic fall_stb_c
);

  localparam int unsigned       CNT_W    = cnt_width(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             stb_c;

  // Strobes fire in the cycle before the edge that moves sck
  assign stb_c      = en && (cnt == CNT_LAST);
  assign rise_stb_c = stb_c && (sck == CPOL);
  assign fall_stb_c = stb_c && (sck != CPOL);

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      cnt <= '0;
      sck <= CPOL;
    end else if (!en) begin
      cnt <= '0;
      sck <= CPOL;
    end else if (stb_c) begin
      cnt <= '0;
      sck <= ~sck;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_master_control.sv
// SPI mode-0 master: one pixel out / one Sobel word back per chip-select frame.
module spi_master_control
  import spi_pkg::*;
#(
  parameter int unsigned DATA_BITS = MAX_PIXEL_BITS,
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned CS_SETUP  = 2,
  parameter int unsigned CS_HOLD   = 2,
  parameter int unsigned CS_GAP    = 4
) (
  input  logic                 clk_i,
  input  logic                 nreset_i,
  spi_master_control_if.slave  bus,
  output logic                 spi_sck_o,
  output logic                 spi_cs_o,
  output logic                 spi_sdo_o,
  input  logic                 spi_sdi_i
);

  localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);
  localparam int unsigned TMAX   = (CS_SETUP > CS_HOLD) ?
                                   ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP) :
                                   ((CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP);
  localparam int unsigned TCNT_W = cnt_width(TMAX);

  localparam logic [TCNT_W-1:0] SETUP_LAST = TCNT_W'(CS_SETUP - 1);
  localparam logic [TCNT_W-1:0] HOLD_LAST  = TCNT_W'(CS_HOLD - 1);
  localparam logic [TCNT_W-1:0] GAP_LAST   = TCNT_W'(CS_GAP - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(DATA_BITS);

  state_e               state, state_d;
  logic [TCNT_W-1:0]    tcnt, tcnt_d;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_d;
  logic [DATA_BITS-1:0] tx_shift, tx_shift_d;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_d;
  logic [DATA_BITS-1:0] rx_data, rx_data_d;
  logic                 rx_valid, rx_valid_d;
  logic                 busy, busy_d;
  logic                 ready, ready_d;
  logic                 cs, cs_d;
  logic                 sdo, sdo_d;
  logic                 sck;
  logic                 rise_stb_c;
  logic                 fall_stb_c;

  spi_master_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk_i      (clk_i),
    .nreset_i   (nreset_i),
    .en         (state == S_SHIFT),
    .sck        (sck),
    .rise_stb_c (rise_stb_c),
    .fall_stb_c (fall_stb_c)
  );

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state    <= S_IDLE;
      tcnt     <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
      ready    <= 1'b1;
      cs       <= 1'b1;
      sdo      <= 1'b0;
    end else begin
      state    <= state_d;
      tcnt     <= tcnt_d;
      bit_cnt  <= bit_cnt_d;
      tx_shift <= tx_shift_d;
      rx_shift <= rx_shift_d;
      rx_data  <= rx_data_d;
      rx_valid <= rx_valid_d;
      busy     <= busy_d;
      ready    <= ready_d;
      cs       <= cs_d;
      sdo      <= sdo_d;
    end
  end

  // Frame sequencer; bit_cnt counts sck rises, the frame ends on the fall after the last one
  always_comb begin
    state_d    = state;
    tcnt_d     = tcnt;
    bit_cnt_d  = bit_cnt;
    tx_shift_d = tx_shift;
    rx_shift_d = rx_shift;
    rx_data_d  = rx_data;
    rx_valid_d = 1'b0;
    busy_d     = busy;
    ready_d    = ready;
    cs_d       = cs;
    sdo_d      = sdo;

    case (state)
      S_IDLE: begin
        if (bus.tx_valid_i && ready) begin
          state_d    = S_CS_SETUP;
          tcnt_d     = '0;
          bit_cnt_d  = '0;
          tx_shift_d = bus.tx_data_i;
          sdo_d      = bus.tx_data_i[DATA_BITS-1];
          cs_d       = 1'b0;
          busy_d     = 1'b1;
          ready_d    = 1'b0;
        end
      end
      S_CS_SETUP: begin
        if (tcnt == SETUP_LAST) begin
          state_d = S_SHIFT;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt + TCNT_W'(1);
        end
      end
      S_SHIFT: begin
        if (rise_stb_c) begin
          bit_cnt_d = bit_cnt + BIT_W'(1);
        end
        if (fall_stb_c) begin
          tx_shift_d = {tx_shift[DATA_BITS-2:0], 1'b0};
          rx_shift_d = {rx_shift[DATA_BITS-2:0], spi_sdi_i};
          if (bit_cnt == BIT_LAST) begin
            state_d = S_CS_HOLD;
            tcnt_d  = '0;
          end else begin
            sdo_d = tx_shift[DATA_BITS-2];
          end
        end
      end
      S_CS_HOLD: begin
        if (tcnt == HOLD_LAST) begin
          state_d    = S_GAP;
          tcnt_d     = '0;
          cs_d       = 1'b1;
          rx_data_d  = rx_shift;
          rx_valid_d = 1'b1;
        end else begin
          tcnt_d = tcnt + TCNT_W'(1);
        end
      end
      S_GAP: begin
        if (tcnt == GAP_LAST) begin
          state_d = S_IDLE;
          tcnt_d  = '0;
          busy_d  = 1'b0;
          ready_d = 1'b1;
        end else begin
          tcnt_d = tcnt + TCNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.tx_ready_o = ready;
  assign bus.rx_data_o  = rx_data;
  assign bus.rx_valid_o = rx_valid;
  assign bus.busy_o     = busy;
  assign spi_sck_o      = sck;
  assign spi_cs_o       = cs;
  assign spi_sdo_o      = sdo;

endmodule

// File: tb/tb_spi_master_control.sv
// Directed bench for spi_master_control: loopback and mode-0 slave BFM frames, back-to-back, reset abort, CLK_DIV=1.
module tb_spi_master_control;
  import spi_pkg::*;

  localparam int unsigned DB = MAX_PIXEL_BITS;

  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  spi_master_control_if #(.DATA_BITS(DB)) bus0 ();
  spi_master_control_if #(.DATA_BITS(DB)) bus1 ();

  logic sck0, cs0, sdo0, sdi0;
  logic sck1, cs1, sdo1;
  bit   loop0;

  logic [DB-1:0] bfm_pre, bfm_sh, bfm_cap;
  logic          bfm_cs_q  = 1'b1;
  logic          bfm_sck_q = 1'b0;

  assign sdi0 = loop0 ? sdo0 : bfm_sh[DB-1];

  spi_master_control #(
    .DATA_BITS(DB), .CLK_DIV(2), .CS_SETUP(2), .CS_HOLD(2), .CS_GAP(4)
  ) dut (
    .clk_i(clk), .nreset_i(nreset), .bus(bus0),
    .spi_sck_o(sck0), .spi_cs_o(cs0), .spi_sdo_o(sdo0), .spi_sdi_i(sdi0)
  );

  spi_master_control #(
    .DATA_BITS(DB), .CLK_DIV(1), .CS_SETUP(2), .CS_HOLD(2), .CS_GAP(4)
  ) dut1 (
    .clk_i(clk), .nreset_i(nreset), .bus(bus1),
    .spi_sck_o(sck1), .spi_cs_o(cs1), .spi_sdo_o(sdo1), .spi_sdi_i(sdo1)
  );

  // Mode-0 slave: MISO updates after sck falls, MOSI captured on sck rise
  always @(cs0 or sck0) begin
    if (bfm_cs_q === 1'b1 && cs0 === 1'b0) begin
      bfm_sh  = bfm_pre;
      bfm_cap = '0;
    end
    if (cs0 === 1'b0 && bfm_sck_q === 1'b0 && sck0 === 1'b1) bfm_cap = {bfm_cap[DB-2:0], sdo0};
    if (cs0 === 1'b0 && bfm_sck_q === 1'b1 && sck0 === 1'b0) bfm_sh = {bfm_sh[DB-2:0], 1'b0};
    bfm_cs_q  = cs0;
    bfm_sck_q = sck0;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One frame on dut, sampled at negedges; n=0 is the sample after the accept edge
  task automatic frame0(input logic [7:0] tx, input bit lp, input logic [7:0] pre,
                        output logic [7:0] rx, output int valid_at, output int nvalid,
                        output int cs_low, output int rises, output int ready_at);
    logic prev;
    loop0   = lp;
    bfm_pre = pre;
    for (int i = 0; i < 100 && bus0.tx_ready_o !== 1'b1; i++) @(negedge clk);
    bus0.tx_data_i  = tx;
    bus0.tx_valid_i = 1'b1;
    @(negedge clk);
    bus0.tx_valid_i = 1'b0;
    bus0.tx_data_i  = ~tx;
    rx = '0; valid_at = -1; nvalid = 0; cs_low = 0; rises = 0; ready_at = -1; prev = 1'b0;
    for (int n = 0; n < 120; n++) begin
      if (cs0 === 1'b0) cs_low++;
      if (sck0 === 1'b1 && !prev) rises++;
      prev = sck0;
      if (bus0.rx_valid_o === 1'b1) begin
        nvalid++;
        valid_at = n;
        rx = bus0.rx_data_o;
      end
      if (bus0.tx_ready_o === 1'b1) begin
        ready_at = n;
        break;
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [7:0] tx;
    bit         lp;
    logic [7:0] pre;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t       vecs [5];
  logic [7:0] bb_w [3];

  initial begin
    logic [7:0] rx;
    int valid_at, nvalid, cs_low, rises, ready_at;
    int idx, rv_n, ng, nr, cs_run, rdy_run, falls, nrise;
    bit pend;
    logic prev;
    int rv_t [3];
    logic [7:0] rv_d [3];
    int gaps [4];
    int rdy_runs [4];
    int r_t [8];

    vecs[0] = '{tx: 8'hA5, lp: 1'b1, pre: 8'h00, exp_rx: 8'hA5};
    vecs[1] = '{tx: 8'hC3, lp: 1'b0, pre: 8'h3C, exp_rx: 8'h3C};
    vecs[2] = '{tx: 8'h01, lp: 1'b0, pre: 8'h80, exp_rx: 8'h80};
    vecs[3] = '{tx: 8'hFF, lp: 1'b1, pre: 8'h00, exp_rx: 8'hFF};
    vecs[4] = '{tx: 8'h00, lp: 1'b0, pre: 8'hFF, exp_rx: 8'hFF};
    bb_w[0] = 8'h00; bb_w[1] = 8'hFF; bb_w[2] = 8'h5A;

    nreset = 1'b0;
    loop0 = 1'b1;
    bfm_pre = '0;
    bus0.tx_data_i = '0; bus0.tx_valid_i = 1'b0;
    bus1.tx_data_i = '0; bus1.tx_valid_i = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_cs", cs0, 1);
    check("rst_sck", sck0, 0);
    check("rst_sdo", sdo0, 0);
    check("rst_rx_data", bus0.rx_data_o, 0);
    check("rst_rx_valid", bus0.rx_valid_o, 0);
    check("rst_busy", bus0.busy_o, 0);
    check("rst_ready", bus0.tx_ready_o, 1);
    check("rst1_cs_sck_ready", {cs1, sck1, bus1.tx_ready_o, bus1.busy_o, bus1.rx_valid_o}, 5'b10100);
    nreset = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      frame0(vecs[v].tx, vecs[v].lp, vecs[v].pre, rx, valid_at, nvalid, cs_low, rises, ready_at);
      check($sformatf("v%0d_rx_data", v), rx, vecs[v].exp_rx);
      check($sformatf("v%0d_bfm_capture", v), bfm_cap, vecs[v].tx);
      check($sformatf("v%0d_valid_latency", v), valid_at, 36);
      check($sformatf("v%0d_valid_pulses", v), nvalid, 1);
      check($sformatf("v%0d_cs_low_cycles", v), cs_low, 36);
      check($sformatf("v%0d_sck_rises", v), rises, 8);
      check($sformatf("v%0d_accept_to_ready", v), ready_at, 40);
    end

    // Back-to-back frames with tx_valid held high
    loop0 = 1'b1;
    idx = 0; rv_n = 0; ng = 0; nr = 0; cs_run = 0; rdy_run = 0; pend = 1'b0;
    bus0.tx_data_i = bb_w[0];
    bus0.tx_valid_i = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if (pend) begin
        idx++;
        if (idx < 3) bus0.tx_data_i = bb_w[idx];
        else bus0.tx_valid_i = 1'b0;
        pend = 1'b0;
      end
      if (bus0.rx_valid_o === 1'b1 && rv_n < 3) begin
        rv_t[rv_n] = n;
        rv_d[rv_n] = bus0.rx_data_o;
        rv_n++;
      end
      if (cs0 === 1'b1) cs_run++;
      else begin
        if (rv_n > 0 && cs_run > 0 && ng < 4) begin gaps[ng] = cs_run; ng++; end
        cs_run = 0;
      end
      if (bus0.tx_ready_o === 1'b1) rdy_run++;
      else begin
        if (rv_n > 0 && rdy_run > 0 && nr < 4) begin rdy_runs[nr] = rdy_run; nr++; end
        rdy_run = 0;
      end
      if (bus0.tx_ready_o === 1'b1 && bus0.tx_valid_i === 1'b1) pend = 1'b1;
      if (rv_n == 3 && bus0.tx_ready_o === 1'b1 && bus0.tx_valid_i === 1'b0) break;
      @(negedge clk);
    end
    check("b2b_frames", rv_n, 3);
    if (rv_n == 3) begin
      check("b2b_rx0", rv_d[0], 8'h00);
      check("b2b_rx1", rv_d[1], 8'hFF);
      check("b2b_rx2", rv_d[2], 8'h5A);
      check("b2b_valid_spacing01", rv_t[1] - rv_t[0], 41);
      check("b2b_valid_spacing12", rv_t[2] - rv_t[1], 41);
    end
    check("b2b_gap_count", ng, 2);
    if (ng == 2) begin
      check("b2b_cs_high0", gaps[0], 5);
      check("b2b_cs_high1", gaps[1], 5);
    end
    check("b2b_ready_count", nr, 2);
    if (nr == 2) begin
      check("b2b_ready_len0", rdy_runs[0], 1);
      check("b2b_ready_len1", rdy_runs[1], 1);
    end

    // Reset after the third sck fall aborts the frame
    @(negedge clk);
    loop0 = 1'b1;
    bus0.tx_data_i = 8'h5A;
    bus0.tx_valid_i = 1'b1;
    @(negedge clk);
    bus0.tx_valid_i = 1'b0;
    falls = 0; prev = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (prev && sck0 === 1'b0) falls++;
      prev = sck0;
      if (falls == 3) break;
      @(negedge clk);
    end
    check("abort_falls_seen", falls, 3);
    check("abort_sdo_before", sdo0, 1);
    nreset = 1'b0;
    @(negedge clk);
    check("abort_cs", cs0, 1);
    check("abort_sck", sck0, 0);
    check("abort_sdo", sdo0, 0);
    check("abort_busy_ready", {bus0.busy_o, bus0.tx_ready_o}, 2'b01);
    nreset = 1'b1;
    nvalid = 0;
    for (int n = 0; n < 60; n++) begin
      if (bus0.rx_valid_o !== 1'b0) nvalid++;
      @(negedge clk);
    end
    check("abort_no_rx_valid", nvalid, 0);
    check("abort_rx_data", bus0.rx_data_o, 0);
    frame0(8'h81, 1'b1, 8'h00, rx, valid_at, nvalid, cs_low, rises, ready_at);
    check("post_abort_rx", rx, 8'h81);
    check("post_abort_latency", valid_at, 36);

    // CLK_DIV=1 loopback on dut1
    bus1.tx_data_i = 8'h96;
    bus1.tx_valid_i = 1'b1;
    @(negedge clk);
    bus1.tx_valid_i = 1'b0;
    bus1.tx_data_i = 8'h00;
    rx = '0; valid_at = -1; ready_at = -1; nrise = 0; prev = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (sck1 === 1'b1 && !prev) begin
        if (nrise < 8) r_t[nrise] = n;
        nrise++;
      end
      prev = sck1;
      if (bus1.rx_valid_o === 1'b1) begin valid_at = n; rx = bus1.rx_data_o; end
      if (bus1.tx_ready_o === 1'b1) begin ready_at = n; break; end
      @(negedge clk);
    end
    check("div1_rx", rx, 8'h96);
    check("div1_rises", nrise, 8);
    if (nrise == 8) begin
      check("div1_sck_period_first", r_t[1] - r_t[0], 2);
      check("div1_sck_period_last", r_t[7] - r_t[6], 2);
    end
    check("div1_valid_latency", valid_at, 20);
    check("div1_accept_to_ready", ready_at, 24);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
